// File: rtl/uart_wb_master.sv
// Wishbone classic initiator for the UART register slave.
// One host request at a time, one bus cycle each, with an ack timeout.
module uart_wb_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  wb_rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          cyc;

  assign req_ready_o = (state == IDLE);
  assign wb_cyc_o    = cyc;
  assign wb_stb_o    = cyc;

  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      timer       <= '0;
      cyc         <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            wb_we_o  <= req_we_i;
            wb_adr_o <= req_addr_i;
            wb_dat_o <= req_wdata_i;
            cyc      <= 1'b1;
            timer    <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          // an ack on the timeout edge still completes the transfer
          if (wb_ack_i) begin
            cyc         <= 1'b0;
            rsp_rdata_o <= wb_we_o ? '0 : wb_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (timer == TLAST) begin
            cyc         <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed + randomized bench for uart_wb_master with a
// UART-like register slave and a transaction-level reference model.
module tb_uart_wb_master;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       wb_rst_ni = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready_o;
  logic       req_we = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid_o;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata_o;
  logic       rsp_err_o;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  int passed = 0;
  int total = 0;

  uart_wb_master #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .wb_rst_ni(wb_rst_ni),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // UART-like slave: ack s_dly cycles into the bus cycle, or never when muted
  int         s_dly = 1;
  bit         s_mute = 1'b0;
  logic       stray = 1'b0;
  int         s_cnt = 0;
  logic       s_ack = 1'b0;
  logic [7:0] smem [0:7] = '{8'h00, 8'h00, 8'h00, 8'h03,
                             8'h00, 8'h60, 8'h00, 8'h00};
  logic [7:0] ref_mem [0:7] = '{8'h00, 8'h00, 8'h00, 8'h03,
                                8'h00, 8'h60, 8'h00, 8'h00};

  always @(posedge clk) begin
    if (!wb_cyc_o) begin
      s_cnt <= 0;
      s_ack <= 1'b0;
    end else begin
      s_cnt <= s_cnt + 1;
      s_ack <= !s_ack && !s_mute && (s_cnt == s_dly - 1);
      if (s_ack && wb_we_o) smem[wb_adr_o] <= wb_dat_o;
    end
  end

  assign wb_ack_i = s_ack | stray;
  assign wb_dat_i = smem[wb_adr_o];

  // bus and handshake monitors
  int         cyc_no = 0;
  int         cyc_total = 0;
  int         ack_total = 0;
  int         acc_q [$];
  logic [8:0] rsp_q [$];

  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (wb_cyc_o) cyc_total <= cyc_total + 1;
    if (wb_cyc_o && wb_ack_i) ack_total <= ack_total + 1;
    if (req_valid && req_ready_o) acc_q.push_back(cyc_no);
    if (rsp_valid_o && rsp_ready) rsp_q.push_back({rsp_err_o, rsp_rdata_o});
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // transaction-level model: {err, rdata}
  function automatic logic [8:0] predict(input logic we, input logic [2:0] a,
                                         input logic [7:0] d, input int dly,
                                         input bit mt);
    logic err;
    err = mt || (dly >= TIMEOUT);
    if (!err && we) ref_mem[a] = d;
    return {err, (err || we) ? 8'h00 : ref_mem[a]};
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] a,
                         input logic [7:0] d, input int dly, input bit mt,
                         input int hold, input string tag);
    logic [8:0] exp;
    int lat, explat, c0, a0;
    exp = predict(we, a, d, dly, mt);
    explat = exp[8] ? TIMEOUT : dly + 1;
    @(negedge clk);
    s_dly = dly;
    s_mute = mt;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    check({tag, ".req_ready"}, 32'(req_ready_o), 32'd1);
    c0 = cyc_total;
    a0 = ack_total;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check({tag, ".cyc"}, 32'(wb_cyc_o), 32'd1);
    check({tag, ".stb"}, 32'(wb_stb_o), 32'd1);
    check({tag, ".we"}, 32'(wb_we_o), 32'(we));
    check({tag, ".adr"}, 32'(wb_adr_o), 32'(a));
    check({tag, ".dat"}, 32'(wb_dat_o), 32'(d));
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!rsp_valid_o && lat < 40);
    check({tag, ".latency"}, 32'(lat), 32'(explat));
    check({tag, ".err"}, 32'(rsp_err_o), 32'(exp[8]));
    check({tag, ".rdata"}, 32'(rsp_rdata_o), 32'(exp[7:0]));
    check({tag, ".cyc_len"}, 32'(cyc_total - c0), 32'(explat));
    check({tag, ".acks"}, 32'(ack_total - a0), exp[8] ? 32'd0 : 32'd1);
    check({tag, ".cyc_end"}, 32'(wb_cyc_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = ~req_valid;
      stray = i[0];
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(rsp_valid_o), 32'd1);
      check({tag, ".hold_data"}, 32'({rsp_err_o, rsp_rdata_o}), 32'(exp));
      check({tag, ".hold_ready"}, 32'(req_ready_o), 32'd0);
      check({tag, ".hold_cyc"}, 32'(wb_cyc_o), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    stray = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, ".idle_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, ".kept_bus"}, 32'({wb_we_o, wb_adr_o, wb_dat_o}),
          32'({we, a, d}));
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_q [$];
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    int         w;

    #12;
    check("rst.cyc", 32'(wb_cyc_o), 32'd0);
    check("rst.stb", 32'(wb_stb_o), 32'd0);
    check("rst.bus", 32'({wb_we_o, wb_adr_o, wb_dat_o}), 32'd0);
    check("rst.rsp", 32'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 32'd0);
    @(negedge clk);
    wb_rst_ni = 1'b1;

    run_txn(1'b1, 3'd3, 8'h83, 1, 1'b0, 0, "wr3");
    run_txn(1'b0, 3'd5, 8'h00, 1, 1'b0, 0, "rd5");
    run_txn(1'b0, 3'd2, 8'h00, 1, 1'b1, 0, "tmo");

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stray = 1'b1;
      @(posedge clk);
      #1;
      check("stray.valid", 32'(rsp_valid_o), 32'd0);
      check("stray.cyc", 32'(wb_cyc_o), 32'd0);
    end
    @(negedge clk);
    stray = 1'b0;

    run_txn(1'b0, 3'd5, 8'h00, 1, 1'b0, 10, "hold");

    // reset while the bus cycle is open
    @(negedge clk);
    s_mute = 1'b1;
    req_we = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("rstbus.cyc", 32'(wb_cyc_o), 32'd0);
    check("rstbus.stb", 32'(wb_stb_o), 32'd0);
    @(negedge clk);
    wb_rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("rstbus.valid", 32'(rsp_valid_o), 32'd0);
    check("rstbus.ready", 32'(req_ready_o), 32'd1);

    // back-to-back alternating read/write, both handshakes held high
    @(negedge clk);
    s_mute = 1'b0;
    s_dly = 1;
    acc_q.delete();
    rsp_q.delete();
    w = ack_total;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      we = k[0];
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      req_we = we;
      req_addr = a;
      req_wdata = d;
      exp_q.push_back(predict(we, a, d, 1, 1'b0));
      for (int t = 0; t < 10 && !req_ready_o; t++) @(negedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b.accepts", 32'(acc_q.size()), 32'd6);
    check("b2b.rsps", 32'(rsp_q.size()), 32'd6);
    check("b2b.acks", 32'(ack_total - w), 32'd6);
    for (int k = 1; k < 6 && k < acc_q.size(); k++)
      check("b2b.interval", 32'(acc_q[k] - acc_q[k-1]), 32'd4);
    for (int k = 0; k < 6 && k < rsp_q.size(); k++)
      check("b2b.rsp", 32'(rsp_q[k]), 32'(exp_q[k]));

    run_txn(1'b0, 3'd3, 8'h00, TIMEOUT - 1, 1'b0, 0, "ack_on_tmo");
    run_txn(1'b1, 3'd6, 8'h5a, TIMEOUT, 1'b0, 0, "ack_late");
    run_txn(1'b0, 3'd6, 8'h00, 1, 1'b0, 0, "rd_after_late");

    for (int k = 0; k < 12; k++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              8'($urandom), $urandom_range(1, 18),
              ($urandom_range(0, 5) == 0), $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
